// File: rtl/conv1_window_mac.sv
// conv1_window_mac: KxK sliding-window MAC over an IMG_W image, two kernels in parallel.
// Define CONV1_RELU_EN to clamp out0/out1 at zero when they are loaded.
module conv1_window_mac #(
    parameter int IMG_W = 28,
    parameter int K     = 5,
    parameter int DW    = 8,
    parameter int ACC_W = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [9:0]       pix_addr,
    input  logic [DW-1:0]    pix_data,
    input  logic [DW-1:0]    w0,
    input  logic [DW-1:0]    w1,
    output logic             k_en,
    output logic             k_restart,
    output logic [ACC_W-1:0] out0,
    output logic [ACC_W-1:0] out1,
    output logic [9:0]       out_addr,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int KW    = $clog2(K);
    localparam int RW    = $clog2(OUT_W);
    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DRAIN = 3'd2, S_EMIT = 3'd3, S_DONE = 3'd4;

    logic [2:0]             state_q, state_d;
    logic [KW-1:0]          ki_q, ki_d, kj_q, kj_d;
    logic [RW-1:0]          row_q, row_d, col_q, col_d;
    logic                   mac_v_q, mac_v_d, first_q, first_d;
    logic [ACC_W-1:0]       acc0_q, acc0_d, acc1_q, acc1_d;
    logic [ACC_W-1:0]       out0_q, out0_d, out1_q, out1_d;
    logic [9:0]             out_addr_q, out_addr_d;
    logic signed [2*DW-1:0] prod0, prod1;
    logic [ACC_W-1:0]       sum0, sum1, fin0, fin1;
    logic                   idle, fetch, drain, emit, kj_last, last_tap, col_last, row_last;

    always_comb begin
        idle     = state_q == S_IDLE;
        fetch    = state_q == S_FETCH;
        drain    = state_q == S_DRAIN;
        emit     = state_q == S_EMIT;
        kj_last  = kj_q == KW'(K-1);
        last_tap = kj_last && ki_q == KW'(K-1);
        col_last = col_q == RW'(OUT_W-1);
        row_last = row_q == RW'(OUT_W-1);
        // Pixel and weights arrive one cycle after their tap was issued.
        prod0    = $signed(pix_data) * $signed(w0);
        prod1    = $signed(pix_data) * $signed(w1);
        sum0     = (first_q ? '0 : acc0_q) + {{(ACC_W-2*DW){prod0[2*DW-1]}}, prod0};
        sum1     = (first_q ? '0 : acc1_q) + {{(ACC_W-2*DW){prod1[2*DW-1]}}, prod1};
`ifdef CONV1_RELU_EN
        fin0     = sum0[ACC_W-1] ? '0 : sum0;
        fin1     = sum1[ACC_W-1] ? '0 : sum1;
`else
        fin0     = sum0;
        fin1     = sum1;
`endif
        state_d    = idle     ? (start ? S_FETCH : S_IDLE) :
                     fetch    ? (last_tap ? S_DRAIN : S_FETCH) :
                     drain    ? S_EMIT :
                     emit     ? ((row_last && col_last) ? S_DONE : S_FETCH) : S_IDLE;
        kj_d       = (fetch && !kj_last) ? kj_q + 1'b1 : '0;
        ki_d       = (!fetch || last_tap) ? '0 : kj_last ? ki_q + 1'b1 : ki_q;
        col_d      = emit ? (col_last ? '0 : col_q + 1'b1) : col_q;
        row_d      = (emit && col_last) ? (row_last ? '0 : row_q + 1'b1) : row_q;
        mac_v_d    = fetch;
        first_d    = fetch && ki_q == '0 && kj_q == '0;
        acc0_d     = mac_v_q ? sum0 : acc0_q;
        acc1_d     = mac_v_q ? sum1 : acc1_q;
        out0_d     = drain ? fin0 : out0_q;
        out1_d     = drain ? fin1 : out1_q;
        out_addr_d = drain ? 10'(row_q) * 10'(OUT_W) + 10'(col_q) : out_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ki_q       <= '0;
            kj_q       <= '0;
            row_q      <= '0;
            col_q      <= '0;
            mac_v_q    <= 1'b0;
            first_q    <= 1'b0;
            acc0_q     <= '0;
            acc1_q     <= '0;
            out0_q     <= '0;
            out1_q     <= '0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ki_q       <= ki_d;
            kj_q       <= kj_d;
            row_q      <= row_d;
            col_q      <= col_d;
            mac_v_q    <= mac_v_d;
            first_q    <= first_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            out0_q     <= out0_d;
            out1_q     <= out1_d;
            out_addr_q <= out_addr_d;
        end
    end

    assign pix_addr  = fetch ? (10'(row_q) + 10'(ki_q)) * 10'(IMG_W) + 10'(col_q) + 10'(kj_q) : '0;
    assign k_en      = fetch;
    assign k_restart = idle || emit || state_q == S_DONE;
    assign out_valid = emit;
    assign busy      = fetch || drain || emit;
    assign done      = state_q == S_DONE;
    assign out0      = out0_q;
    assign out1      = out1_q;
    assign out_addr  = out_addr_q;
endmodule

// File: tb/tb_conv1_window_mac.sv
// tb_conv1_window_mac: directed bench with image RAM and weight-counter models for conv1_window_mac.
module tb_conv1_window_mac;
    localparam int IMG_W = 28, K = 5, DW = 8, ACC_W = 21, OUT_W = 24;

    typedef struct {
        int     pix;
        int     w0;
        int     w1;
        longint e0;
        longint e1;
    } vec_t;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0;
    logic [9:0] pix_addr, out_addr;
    logic [DW-1:0] pix_data = '0, w0 = '0, w1 = '0;
    logic k_en, k_restart, out_valid, busy, done;
    logic [ACC_W-1:0] out0, out1;
    int tests = 0, fails = 0, cyc = 0, wtap = 0;
    int img_mode = 0, pix_c = 0;
    int k0[K*K], k1[K*K];
    vec_t tab[5];

    always #5 clk = ~clk;

    conv1_window_mac dut (
        .clk(clk), .reset(reset), .start(start), .pix_addr(pix_addr), .pix_data(pix_data),
        .w0(w0), .w1(w1), .k_en(k_en), .k_restart(k_restart), .out0(out0), .out1(out1),
        .out_addr(out_addr), .out_valid(out_valid), .busy(busy), .done(done)
    );

    function automatic int img(input int a);
        return img_mode == 0 ? pix_c : (a % 256) - 128;
    endfunction

    function automatic longint relu(input longint v);
`ifdef CONV1_RELU_EN
        return v < 0 ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic longint wsum(input int r, input int c, input bit sel);
        longint s = 0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                s += longint'(img((r + i) * IMG_W + c + j)) * longint'(sel ? k1[i*K+j] : k0[i*K+j]);
        return relu(s);
    endfunction

    // Sync image RAM and a weight counter that presents tap t the cycle after stepping from t.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pix_data <= DW'(img(int'(pix_addr)));
        if (k_restart) wtap <= 0;
        else if (k_en) begin
            wtap <= wtap + 1;
            w0 <= DW'(k0[wtap % (K*K)]);
            w1 <= DW'(k1[wtap % (K*K)]);
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, ".pix_addr"}, longint'(pix_addr), 0);
        chk({nm, ".out0"}, longint'(out0), 0);
        chk({nm, ".out1"}, longint'(out1), 0);
        chk({nm, ".out_addr"}, longint'(out_addr), 0);
        chk({nm, ".out_valid"}, longint'(out_valid), 0);
        chk({nm, ".busy"}, longint'(busy), 0);
        chk({nm, ".done"}, longint'(done), 0);
        chk({nm, ".k_en"}, longint'(k_en), 0);
        chk({nm, ".k_restart"}, longint'(k_restart), 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at the negedge showing tap 0 of window 'first'; leaves at tap 0 of the next window.
    task automatic run_windows(input int first, input int n, input bit use_tab,
                               input longint e0, input longint e1, input bit pulse);
        int idx, r, c, ken, n_c;
        bit got;
        for (int w = 0; w < n; w++) begin
            idx = first + w;
            r = idx / OUT_W;
            c = idx % OUT_W;
            ken = 0;
            n_c = 0;
            got = 1'b0;
            while (!got && n_c < 60) begin
                start = pulse && w == 1 && n_c == 4;
                if (out_valid) begin
                    got = 1'b1;
                    chk("out_addr", longint'(out_addr), idx);
                    chk("out0", longint'($signed(out0)), use_tab ? relu(e0) : wsum(r, c, 1'b0));
                    chk("out1", longint'($signed(out1)), use_tab ? relu(e1) : wsum(r, c, 1'b1));
                    chk("emit.k_restart", longint'(k_restart), 1);
                    chk("emit.busy", longint'(busy), 1);
                    chk("emit.k_en", longint'(k_en), 0);
                end else if (k_en) begin
                    chk("pix_addr", longint'(pix_addr), (r + ken / K) * IMG_W + c + ken % K);
                    ken++;
                end
                @(negedge clk);
                n_c++;
            end
            start = 1'b0;
            chk("window_emitted", longint'(got), 1);
            chk("k_en_per_window", ken, K*K);
            chk("cycles_per_window", n_c, K*K + 2);
        end
    endtask

    initial begin
        int c0, nv;
        tab[0] = '{pix: 1,    w0: 1,    w1: -1,   e0: 25,     e1: -25};
        tab[1] = '{pix: -128, w0: -128, w1: 127,  e0: 409600, e1: -406400};
        tab[2] = '{pix: 3,    w0: 2,    w1: -5,   e0: 150,    e1: -375};
        tab[3] = '{pix: 127,  w0: 127,  w1: -128, e0: 403225, e1: -406400};
        tab[4] = '{pix: 0,    w0: 5,    w1: 7,    e0: 0,      e1: 0};
        for (int i = 0; i < K*K; i++) begin
            k0[i] = 0;
            k1[i] = 0;
        end
        repeat (3) @(negedge clk);
        chk_reset("reset");
        reset = 1'b1;
        @(negedge clk);
        chk("idle.busy", longint'(busy), 0);

        // Uniform image/kernels: three windows each, then abort by reset.
        for (int v = 0; v < 5; v++) begin
            img_mode = 0;
            pix_c = tab[v].pix;
            for (int i = 0; i < K*K; i++) begin
                k0[i] = tab[v].w0;
                k1[i] = tab[v].w1;
            end
            pulse_start();
            run_windows(0, 3, 1'b1, tab[v].e0, tab[v].e1, 1'b0);
            reset = 1'b0;
            @(negedge clk);
            chk_reset("abort");
            reset = 1'b1;
            @(negedge clk);
        end

        // Reset 100 cycles into a run: immediate abort, nothing emitted while held.
        img_mode = 1;
        for (int i = 0; i < K*K; i++) begin
            k0[i] = int'($urandom_range(255)) - 128;
            k1[i] = int'($urandom_range(255)) - 128;
        end
        pulse_start();
        repeat (100) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_reset("mid_reset");
        nv = 0;
        repeat (5) begin
            @(negedge clk);
            nv += int'(out_valid) + int'(busy);
        end
        chk("held_reset.activity", nv, 0);
        reset = 1'b1;
        @(negedge clk);

        // Fresh full map: ramp image, random kernels, stray start pulses.
        pulse_start();
        c0 = cyc;
        run_windows(0, OUT_W*OUT_W, 1'b0, 0, 0, 1'b1);
        chk("done", longint'(done), 1);
        chk("done.busy", longint'(busy), 0);
        chk("done.k_restart", longint'(k_restart), 1);
        chk("done.out_valid", longint'(out_valid), 0);
        chk("done.latency", cyc - c0, OUT_W*OUT_W*(K*K + 2));
        chk("done.out_addr", longint'(out_addr), OUT_W*OUT_W - 1);
        chk("done.out0_hold", longint'($signed(out0)), wsum(OUT_W-1, OUT_W-1, 1'b0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done.one_cycle", longint'(done), 0);
        chk("after_done.busy", longint'(busy), 0);
        @(negedge clk);
        chk("start_in_done_ignored.busy", longint'(busy), 0);
        chk("start_in_done_ignored.k_en", longint'(k_en), 0);
        chk("idle.k_restart", longint'(k_restart), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
